// File: rtl/cdp_icvt_chn_out_buf_if.sv
`default_nettype none
// ============================================================================
//  Module      : cdp_icvt_chn_out_buf_if
//  Description : Downstream pvld/prdy/pd channel of the CDP input-converter
//                output buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface cdp_icvt_chn_out_buf_if #(
   parameter int DATA_W = 9
);
   logic              pvld;
   logic              prdy;
   logic [DATA_W-1:0] pd;

   // Producer side: the output buffer
   modport master (
      output pvld,
      output pd,
      input  prdy
   );

   // Consumer side: downstream logic
   modport slave (
      input  pvld,
      input  pd,
      output prdy
   );
endinterface
`default_nettype wire

// File: rtl/cdp_icvt_chn_out_buf.sv
`default_nettype none
// ============================================================================
//  Module      : cdp_icvt_chn_out_buf
//  Description : Output-channel stage of the CDP input converter core.
//                Buffers core write words in a small FIFO, presents them on a
//                pvld/prdy handshake, reports write-completion to the core
//                staller and counts stalled core cycles (saturating).
//  Revision    : 1.0 - initial release
// ============================================================================
module cdp_icvt_chn_out_buf #(
   parameter int DATA_W = 9,
   parameter int DEPTH  = 2,
   parameter int CNT_W  = 16
) (
   input  wire logic               nvdla_core_clk,
   input  wire logic               nvdla_core_rstn,
   input  wire logic               core_wen,
   input  wire logic               core_wten,
   input  wire logic               chn_out_iswt0,
   input  wire logic [DATA_W-1:0]  chn_out_d,
   output logic                    chn_data_out_rsci_wen_comp,
   cdp_icvt_chn_out_buf_if.master  chn_data_out,
   input  wire logic               perf_clr,
   output logic [CNT_W-1:0]        perf_stall_cnt
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     rd_ptr;
   logic [AW-1:0]     wr_ptr;
   logic [CW-1:0]     count;
   logic              full;
   logic              empty;
   logic              push;
   logic              pop;

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);

   // Completion only looks at the core's request and registered occupancy,
   // never at core_wen or prdy, so no loop forms through the staller.
   assign chn_data_out_rsci_wen_comp = !chn_out_iswt0 || !full;

   assign push = chn_out_iswt0 && core_wen;
   assign pop  = chn_data_out.pvld && chn_data_out.prdy;

   // Output is driven straight from registered state: no bypass path
   assign chn_data_out.pvld = !empty;
   assign chn_data_out.pd   = mem[rd_ptr];

   // FIFO storage write; cleared on reset so pd reads zero afterwards
   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (push) begin
         mem[wr_ptr] <= chn_out_d;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
      end
   end

   // Occupancy tracking; simultaneous push and pop leaves it unchanged
   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         count <= '0;
      end else begin
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Saturating stall counter; clear wins over increment
   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         perf_stall_cnt <= '0;
      end else if (perf_clr) begin
         perf_stall_cnt <= '0;
      end else if (core_wten && (perf_stall_cnt != {CNT_W{1'b1}})) begin
         perf_stall_cnt <= perf_stall_cnt + CNT_W'(1);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_cdp_icvt_chn_out_buf.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cdp_icvt_chn_out_buf
//  Description : Self-checking bench for cdp_icvt_chn_out_buf with a queue
//                reference model, directed scenarios and random traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cdp_icvt_chn_out_buf;

   localparam int DATA_W = 9;
   localparam int DEPTH  = 2;
   localparam int CNT_W  = 16;
   localparam int SAT    = (1 << CNT_W) - 1;

   logic              clk;
   logic              rstn;
   logic              core_wen;
   logic              core_wten;
   logic              iswt0;
   logic [DATA_W-1:0] din;
   logic              wen_comp;
   logic              perf_clr;
   logic [CNT_W-1:0]  perf_cnt;

   cdp_icvt_chn_out_buf_if #(.DATA_W(DATA_W)) out_if ();

   cdp_icvt_chn_out_buf #(
      .DATA_W(DATA_W),
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) dut (
      .nvdla_core_clk             (clk),
      .nvdla_core_rstn            (rstn),
      .core_wen                   (core_wen),
      .core_wten                  (core_wten),
      .chn_out_iswt0              (iswt0),
      .chn_out_d                  (din),
      .chn_data_out_rsci_wen_comp (wen_comp),
      .chn_data_out               (out_if.master),
      .perf_clr                   (perf_clr),
      .perf_stall_cnt             (perf_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: pending words in order, plus stall counter value
   logic [DATA_W-1:0] q[$];
   int                m_perf = 0;
   bit                prev_stall;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Apply this cycle's inputs; the staller forms core_wen from wen_comp
   task automatic set_in(input bit iw, input logic [DATA_W-1:0] dd, input bit pr,
                         input bit in_comp, input bit wt, input bit cl);
      iswt0       = iw;
      din         = dd;
      out_if.prdy = pr;
      core_wten   = wt;
      perf_clr    = cl;
      #1;
      core_wen = in_comp & wen_comp;
      #1;
   endtask

   // Compare against the model, clock once, advance the model
   task automatic finish_cycle(input bit do_chk);
      bit mfull, push, pop;
      mfull = (q.size() == DEPTH);
      push  = iswt0 && core_wen && rstn;
      pop   = (q.size() != 0) && out_if.prdy && rstn;
      if (do_chk) begin
         chk("pvld", out_if.pvld, q.size() != 0);
         if (q.size() != 0) chk("pd", out_if.pd, q[0]);
         chk("wen_comp", wen_comp, !iswt0 || !mfull);
         chk("perf", perf_cnt, m_perf);
         chk("push_when_full", push && mfull, 0);
      end
      @(posedge clk);
      if (rstn) begin
         if (pop) void'(q.pop_front());
         if (push && !mfull) q.push_back(din);
         if (perf_clr) m_perf = 0;
         else if (core_wten && m_perf < SAT) m_perf++;
      end
      #1;
   endtask

   initial begin
      rstn = 1'b0;
      core_wen = 0; core_wten = 0; iswt0 = 0; din = '0; perf_clr = 0;
      out_if.prdy = 0;
      #1;
      // Reset state
      chk("rst_pvld", out_if.pvld, 0);
      chk("rst_pd", out_if.pd, 0);
      chk("rst_perf", perf_cnt, 0);
      repeat (2) begin set_in(0, 0, 0, 1, 0, 0); finish_cycle(1); end
      rstn = 1'b1;

      // Single word: push at cycle 5, visible next cycle, gone after
      repeat (4) begin set_in(0, 0, 1, 1, 0, 0); finish_cycle(1); end
      set_in(1, 9'h1A5, 1, 1, 0, 0);
      chk("sw_pvld_n", out_if.pvld, 0);
      finish_cycle(1);
      set_in(0, 0, 1, 1, 0, 0);
      chk("sw_pvld_n1", out_if.pvld, 1);
      chk("sw_pd_n1", out_if.pd, 9'h1A5);
      finish_cycle(1);
      set_in(0, 0, 1, 1, 0, 0);
      chk("sw_pvld_n2", out_if.pvld, 0);
      finish_cycle(1);

      // Reset mid-stream with one entry held
      set_in(1, 9'h0AB, 0, 1, 0, 0); finish_cycle(1);
      set_in(1, 9'h0CD, 0, 1, 0, 0);
      chk("mr_pvld_before", out_if.pvld, 1);
      #2;
      rstn = 1'b0;
      #1;
      chk("mr_pvld", out_if.pvld, 0);
      chk("mr_pd", out_if.pd, 0);
      chk("mr_wen_comp", wen_comp, 1);
      q.delete();
      m_perf = 0;
      set_in(0, 0, 1, 1, 0, 0); finish_cycle(1);
      rstn = 1'b1;
      repeat (3) begin
         set_in(0, 0, 1, 1, 0, 0);
         chk("mr_idle_pvld", out_if.pvld, 0);
         finish_cycle(1);
      end

      // Backpressure fill
      set_in(1, 9'h011, 0, 1, 0, 0); finish_cycle(1);
      set_in(1, 9'h022, 0, 1, 0, 0); finish_cycle(1);
      set_in(1, 9'h033, 0, 1, 0, 0);
      chk("bp_wen_comp_full", wen_comp, 0);
      chk("bp_pd_hold", out_if.pd, 9'h011);
      finish_cycle(1);
      set_in(1, 9'h033, 1, 1, 0, 0);
      chk("bp_wen_comp_full2", wen_comp, 0);
      chk("bp_pd_first", out_if.pd, 9'h011);
      finish_cycle(1);
      set_in(1, 9'h033, 1, 1, 0, 0);
      chk("bp_wen_comp_after_pop", wen_comp, 1);
      chk("bp_pd_second", out_if.pd, 9'h022);
      finish_cycle(1);
      set_in(0, 0, 1, 1, 0, 0);
      chk("bp_pvld_third", out_if.pvld, 1);
      chk("bp_pd_third", out_if.pd, 9'h033);
      finish_cycle(1);
      set_in(0, 0, 1, 1, 0, 0);
      chk("bp_drained", out_if.pvld, 0);
      finish_cycle(1);

      // Streaming at occupancy 1 with simultaneous push/pop
      set_in(1, 9'h100, 0, 1, 0, 0); finish_cycle(1);
      for (int i = 0; i < 50; i++) begin
         set_in(1, 9'(9'h101 + i), 1, 1, 0, 0);
         chk("st_pvld", out_if.pvld, 1);
         chk("st_pd", out_if.pd, 9'(9'h100 + i));
         chk("st_wen_comp", wen_comp, 1);
         finish_cycle(1);
      end
      set_in(0, 0, 1, 1, 0, 0); finish_cycle(1);
      set_in(0, 0, 1, 1, 0, 0);
      chk("st_drained", out_if.pvld, 0);
      finish_cycle(1);

      // Stall counter: count, clear priority, saturation
      set_in(0, 0, 1, 1, 0, 1); finish_cycle(1);
      repeat (10) begin set_in(0, 0, 1, 1, 1, 0); finish_cycle(1); end
      chk("perf_10", perf_cnt, 10);
      set_in(0, 0, 1, 1, 1, 1); finish_cycle(1);
      chk("perf_clr_prio", perf_cnt, 0);
      repeat (SAT - 1) begin set_in(0, 0, 1, 1, 1, 0); finish_cycle(0); end
      chk("perf_fffe", perf_cnt, 16'hFFFE);
      for (int i = 0; i < 3; i++) begin
         set_in(0, 0, 1, 1, 1, 0); finish_cycle(1);
         chk("perf_sat", perf_cnt, 16'hFFFF);
      end
      set_in(0, 0, 1, 1, 0, 1); finish_cycle(1);

      // Random traffic with the staller model
      prev_stall = 1'b0;
      for (int i = 0; i < 10000; i++) begin
         set_in($urandom_range(0, 99) < 60, 9'($urandom), $urandom_range(0, 99) < 55,
                $urandom_range(0, 99) < 80, prev_stall, $urandom_range(0, 499) == 0);
         finish_cycle(1);
         prev_stall = !core_wen;
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
